// File: rtl/fetch_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Instruction fetch sequencer: issues byte fetches, buffers them in a
//            2-entry FIFO, handles redirects and halt. Option: FETCH_CTRL_PERF_EN
// Revision : 1.0
// ============================================================================
module fetch_controller #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [7:0]  imem_data,
    output logic        instr_valid,
    output logic [7:0]  instr_data,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] perf_fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic        r_inflight;
    logic [15:0] r_inflight_pc;
    logic [7:0]  r_fifo_data [2];
    logic [15:0] r_fifo_pc   [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_xfer;
    logic        w_halt_xfer;
    logic        w_redirect;
    logic        w_flush;
    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic [2:0]  w_occ;

    assign instr_valid = (r_count != 2'd0);
    assign instr_data  = r_fifo_data[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];
    assign halted      = (r_state == S_HALTED);

    assign w_xfer      = instr_valid & instr_ready;
    assign w_halt_xfer = w_xfer && (instr_data == HALT_OPCODE) && (r_state == S_FETCH);
    assign w_redirect  = branch_valid && (r_state != S_IDLE);
    assign w_flush     = w_redirect || w_halt_xfer;
    assign w_push      = r_inflight && !w_flush;
    assign w_pop       = w_xfer && !w_flush;

    // A transfer this cycle frees a slot, so it counts as credit; this keeps one
    // transfer per cycle sustainable with a single-cycle memory.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_issue = (r_state == S_FETCH) && !w_flush && (w_occ < 3'd2);

    // A redirect drives its target straight to memory in the strobe cycle.
    assign imem_addr = w_redirect ? branch_target : r_pc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (branch_valid)     w_state_nxt = S_FETCH;
                else if (w_halt_xfer) w_state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (branch_valid) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
        end else begin
            if (r_state == S_IDLE) begin
                if (run) r_pc <= RESET_PC;
            end else if (w_redirect) begin
                r_pc <= branch_target + 16'd1;
            end else if (w_issue) begin
                r_pc <= r_pc + 16'd1;
            end
            r_inflight <= w_redirect || w_issue;
            if (w_redirect || w_issue) begin
                r_inflight_pc <= imem_addr;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_data[0] <= 8'h00;
            r_fifo_data[1] <= 8'h00;
            r_fifo_pc[0]   <= 16'h0000;
            r_fifo_pc[1]   <= 16'h0000;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (w_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= imem_data;
                r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf <= 16'h0000;
        end else if (w_xfer) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_fetch_count = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Scoreboard bench for fetch_controller (default and RESET_PC=FFFF).
// Revision : 1.0
// ============================================================================
module tb_fetch_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        run = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr;
    logic [7:0]  imem_data;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        halted;

    logic        run_w = 1'b0;
    logic        branch_w = 1'b0;
    logic [15:0] target_w = 16'h0000;
    logic [15:0] imem_addr_w;
    logic [7:0]  imem_data_w;
    logic        valid_w;
    logic [7:0]  data_w;
    logic [15:0] pc_w;
    logic        ready_w = 1'b0;
    logic        halted_w;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf;
    logic [15:0] perf_w;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  data;
        int          cyc;
    } xfer_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  data;
    } exp_t;

    logic [7:0] mem [0:65535];
    xfer_t      obs_q[$];
    xfer_t      obs_w_q[$];
    exp_t       exp_q[$];
    xfer_t      mon_t;
    xfer_t      mon_tw;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    fetch_controller dut (
        .clock(clock), .reset_n(reset_n), .run(run),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_fetch_count(perf)
`endif
    );

    fetch_controller #(.RESET_PC(16'hFFFF), .HALT_OPCODE(8'hFF)) dut_w (
        .clock(clock), .reset_n(reset_n), .run(run_w),
        .branch_valid(branch_w), .branch_target(target_w),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .instr_valid(valid_w), .instr_data(data_w), .instr_pc(pc_w),
        .instr_ready(ready_w), .halted(halted_w)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_fetch_count(perf_w)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        imem_data   <= mem[imem_addr];
        imem_data_w <= mem[imem_addr_w];
    end

    always @(negedge clock) begin
        if (reset_n && instr_valid && instr_ready) begin
            mon_t.pc = instr_pc; mon_t.data = instr_data; mon_t.cyc = cyc;
            obs_q.push_back(mon_t);
        end
        if (reset_n && valid_w && ready_w) begin
            mon_tw.pc = pc_w; mon_tw.data = data_w; mon_tw.cyc = cyc;
            obs_w_q.push_back(mon_tw);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc = pc;
        e.data = mem[pc];
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0;
        run_w = 1'b0; ready_w = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        obs_q.delete(); obs_w_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL rst_imem_addr got=%h exp=0000", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        tests++; if (instr_data !== 8'h00) begin fails++; $display("FAIL rst_instr_data got=%h exp=00", instr_data); end
        tests++; if (instr_pc !== 16'h0000) begin fails++; $display("FAIL rst_instr_pc got=%h exp=0000", instr_pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%b exp=0", halted); end
        tests++; if (imem_addr_w !== 16'hFFFF) begin fails++; $display("FAIL rst_imem_addr_w got=%h exp=ffff", imem_addr_w); end
`ifdef FETCH_CTRL_PERF_EN
        tests++; if (perf !== 16'h0000) begin fails++; $display("FAIL rst_perf got=%h exp=0000", perf); end
`endif
        do_reset();
        branch_valid = 1'b1; branch_target = 16'h0055;
        tick();
        branch_valid = 1'b0;
        repeat (4) tick();
        tests++; if (imem_addr !== 16'h0000 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            fails++; $display("FAIL idle_branch addr=%h valid=%b halted=%b exp addr=0000 valid=0 halted=0", imem_addr, instr_valid, halted);
        end
    endtask

    task automatic test_basic();
        int   c0;
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(i[15:0]);
        instr_ready = 1'b1; run = 1'b1; c0 = cyc;
        for (int k = 0; k < 30 && obs_q.size() < 4; k++) tick();
        instr_ready = 1'b0; run = 1'b0;
        tests++; if (obs_q.size() < 4) begin fails++; $display("FAIL basic_timeout got=%0d exp=4 transfers", obs_q.size()); end
`ifdef FETCH_CTRL_PERF_EN
        tests++; if (perf !== 16'(obs_q.size())) begin fails++; $display("FAIL basic_perf got=%0d exp=%0d", perf, obs_q.size()); end
`endif
        if (obs_q.size() >= 4) begin
            tests++; if (obs_q[0].cyc != c0 + 3) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", obs_q[0].cyc - c0, 3); end
            for (int i = 1; i < 4; i++) begin
                tests++; if (obs_q[i].cyc != obs_q[0].cyc + i) begin fails++; $display("FAIL basic_back_to_back idx=%0d got=%0d exp=%0d", i, obs_q[i].cyc, obs_q[0].cyc + i); end
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL basic_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
    endtask

    task automatic test_stall();
        exp_t        e;
        int          n;
        logic [15:0] h_pc;
        logic [7:0]  h_data;
        do_reset();
        for (int i = 0; i < 10; i++) push_exp(i[15:0]);
        instr_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 30 && obs_q.size() < 3; k++) tick();
        instr_ready = 1'b0;
        n = obs_q.size();
        h_pc = instr_pc; h_data = instr_data;
        tests++; if (instr_valid !== 1'b1 || h_pc !== 16'(n) || h_data !== mem[n]) begin
            fails++; $display("FAIL stall_head valid=%b got=%h@%h exp=%h@%h", instr_valid, h_data, h_pc, mem[n], 16'(n));
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if (instr_valid !== 1'b1 || instr_pc !== h_pc || instr_data !== h_data) begin
                fails++; $display("FAIL stall_hold cyc=%0d got=%b %h@%h exp=1 %h@%h", k, instr_valid, instr_data, instr_pc, h_data, h_pc);
            end
        end
        tests++; if (imem_addr !== h_pc + 16'd2 || obs_q.size() != n) begin
            fails++; $display("FAIL stall_no_issue addr=%h xfers=%0d exp addr=%h xfers=%0d", imem_addr, obs_q.size(), h_pc + 16'd2, n);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 30 && obs_q.size() < 10; k++) tick();
        instr_ready = 1'b0; run = 1'b0;
        tests++; if (obs_q.size() < 10) begin fails++; $display("FAIL stall_timeout got=%0d exp=10 transfers", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL stall_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        int   cs;
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(i[15:0]);
        push_exp(16'h0080); push_exp(16'h0081); push_exp(16'h0082);
        instr_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 30 && !(instr_valid && instr_pc == 16'h0005); k++) tick();
        tests++; if (!(instr_valid && instr_pc == 16'h0005)) begin fails++; $display("FAIL branch_wait got pc=%h exp pc=0005", instr_pc); end
        branch_valid = 1'b1; branch_target = 16'h0080; cs = cyc;
        tick();
        branch_valid = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL branch_flush got valid=%b exp=0", instr_valid); end
        for (int k = 0; k < 30 && obs_q.size() < 9; k++) tick();
        instr_ready = 1'b0; run = 1'b0;
        tests++; if (obs_q.size() < 9) begin
            fails++; $display("FAIL branch_timeout got=%0d exp=9 transfers", obs_q.size());
        end else if (obs_q[6].cyc != cs + 2) begin
            fails++; $display("FAIL branch_latency got=%0d exp=2 cycles", obs_q[6].cyc - cs);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL branch_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        mem[2] = 8'hFF;
        do_reset();
        push_exp(16'h0000); push_exp(16'h0001); push_exp(16'h0002);
        instr_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 30 && !halted; k++) tick();
        tests++; if (halted !== 1'b1 || instr_valid !== 1'b0 || obs_q.size() != 3) begin
            fails++; $display("FAIL halt_enter halted=%b valid=%b xfers=%0d exp 1 0 3", halted, instr_valid, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL halt_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
        repeat (3) tick();
        tests++; if (halted !== 1'b1 || obs_q.size() != 0) begin
            fails++; $display("FAIL halt_hold halted=%b xfers=%0d exp 1 0", halted, obs_q.size());
        end
        exp_q.delete();
        push_exp(16'h0010); push_exp(16'h0011);
        branch_valid = 1'b1; branch_target = 16'h0010;
        tick();
        branch_valid = 1'b0;
        for (int k = 0; k < 30 && obs_q.size() < 2; k++) tick();
        instr_ready = 1'b0; run = 1'b0;
        tests++; if (halted !== 1'b0 || obs_q.size() < 2) begin
            fails++; $display("FAIL halt_resume halted=%b xfers=%0d exp 0 2", halted, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL halt_resume_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
        mem[2] = 8'h12;
    endtask

    task automatic test_branch_halt();
        exp_t e;
        mem[2] = 8'hFF;
        do_reset();
        push_exp(16'h0000); push_exp(16'h0001); push_exp(16'h0002);
        push_exp(16'h0040); push_exp(16'h0041);
        instr_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 30 && !(instr_valid && instr_pc == 16'h0002); k++) tick();
        branch_valid = 1'b1; branch_target = 16'h0040;
        tick();
        branch_valid = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL branch_beats_halt got halted=%b exp=0", halted); end
        for (int k = 0; k < 30 && obs_q.size() < 5; k++) tick();
        instr_ready = 1'b0; run = 1'b0;
        tests++; if (obs_q.size() < 5) begin fails++; $display("FAIL branch_halt_timeout got=%0d exp=5 transfers", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL branch_halt_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
        mem[2] = 8'h12;
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        push_exp(16'hFFFF); push_exp(16'h0000); push_exp(16'h0001);
        ready_w = 1'b1; run_w = 1'b1;
        for (int k = 0; k < 30 && obs_w_q.size() < 3; k++) tick();
        ready_w = 1'b0; run_w = 1'b0;
        tests++; if (obs_w_q.size() < 3) begin fails++; $display("FAIL wrap_timeout got=%0d exp=3 transfers", obs_w_q.size()); end
        while (exp_q.size() > 0 && obs_w_q.size() > 0) begin
            e = exp_q.pop_front(); mon_t = obs_w_q.pop_front();
            tests++; if (mon_t.pc !== e.pc || mon_t.data !== e.data) begin
                fails++; $display("FAIL wrap_xfer got=%h@%h exp=%h@%h", mon_t.data, mon_t.pc, e.data, e.pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        repeat (5) tick();
        instr_ready = 1'b0;
        repeat (4) tick();
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL mid_full got valid=%b exp=1", instr_valid); end
`ifdef FETCH_CTRL_PERF_EN
        tests++; if (perf !== 16'(obs_q.size()) || perf == 16'h0000) begin
            fails++; $display("FAIL mid_perf_count got=%0d exp=%0d (nonzero)", perf, obs_q.size());
        end
`endif
        #2 reset_n = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0000 || halted !== 1'b0) begin
            fails++; $display("FAIL mid_reset valid=%b addr=%h halted=%b exp 0 0000 0", instr_valid, imem_addr, halted);
        end
`ifdef FETCH_CTRL_PERF_EN
        tests++; if (perf !== 16'h0000) begin fails++; $display("FAIL mid_reset_perf got=%h exp=0000", perf); end
`endif
        run = 1'b0;
        tick();
        obs_q.delete();
        reset_n = 1'b1; instr_ready = 1'b1;
        repeat (6) tick();
        instr_ready = 1'b0;
        tests++; if (obs_q.size() != 0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL mid_no_xfer xfers=%0d valid=%b exp 0 0", obs_q.size(), instr_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {1'b0, i[6:0] ^ i[13:7]};
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_halt();
        test_branch_halt();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after run.
REQ-002 SHALL have parameter HALT_OPCODE, default 8'hFF, meaning the opcode that stops fetching.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level; starts fetching from IDLE.
REQ-006 SHALL have port branch_valid  input  1  one-cycle redirect strobe.
REQ-007 SHALL have port branch_target  input  16  redirect address.
REQ-008 SHALL have port imem_addr  output  16  instruction memory address.
REQ-009 SHALL have port imem_data  input  8  memory read data, valid one cycle after imem_addr is sampled.
REQ-010 SHALL have port instr_valid  output  1  instr_data/instr_pc hold a valid instruction.
REQ-011 SHALL have port instr_data  output  8  delivered instruction byte.
REQ-012 SHALL have port instr_pc  output  16  address of instr_data.
REQ-013 SHALL have port instr_ready  input  1  consumer accepts; transfer = instr_valid & instr_ready.
REQ-014 SHALL have port halted  output  1  high in HALTED state.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HALTED.
REQ-016 IDLE->FETCH when run=1; pc loads RESET_PC.
REQ-017 In FETCH, SHALL issue a fetch (imem_addr=pc, pc<=pc+1) whenever buffered entries + in-flight fetches < 2.
REQ-018 SHALL capture imem_data with its address into a 2-entry FIFO the cycle after issue; head drives instr_data/instr_pc.
REQ-019 pc SHALL wrap 16'hFFFF -> 16'h0000 with no error indication.
REQ-020 With instr_ready held high and no redirects, SHALL sustain one transfer per cycle after a first-instruction latency of 2 cycles from entering FETCH.
REQ-021 instr_valid SHALL stay high and instr_data/instr_pc stable while instr_ready=0.
REQ-022 FIFO full: no issue; FIFO empty: instr_valid=0; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-023 branch_valid in FETCH SHALL flush FIFO and in-flight fetch and set pc<=branch_target; instr_valid=0 next cycle; first redirected instruction valid 2 cycles after the strobe.
REQ-024 Transfer and branch_valid in the same cycle: the transfer completes, then the flush applies.
REQ-025 Transfer with instr_data==HALT_OPCODE SHALL enter HALTED: flush, stop issuing, instr_valid=0, halted=1.
REQ-026 branch_valid in HALTED SHALL enter FETCH at branch_target; run has no effect in HALTED.
REQ-027 branch_valid coincident with a HALT_OPCODE transfer: branch wins, state FETCH.
REQ-028 branch_valid in IDLE SHALL be ignored.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, pc=RESET_PC, FIFO empty, no in-flight fetch.
REQ-030 Reset values: imem_addr=RESET_PC, instr_valid=0, instr_data=8'h00, instr_pc=16'h0000, halted=0.
REQ-031 Reset mid-operation SHALL discard all buffered and in-flight instructions; no transfer after release until a new run.

Configuration
REQ-032 Macro FETCH_CTRL_PERF_EN defined: SHALL add output perf_fetch_count (16 bits), counting transfers, wrapping, cleared by reset.
REQ-033 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, run=1, ready=1, mem[0..3]=10,11,12,13 -> transfers 10@0,11@1,12@2,13@3 on consecutive cycles, first 2 cycles after FETCH.
REQ-035 ready=0 for 5 cycles mid-stream -> FIFO fills to 2, no issue, instr_data stable; resume -> no loss or duplication.
REQ-036 branch_valid, target 16'h0080, same cycle as transfer of pc 5 -> pc 5 accepted, next transfer pc 16'h0080.
REQ-037 mem[2]=8'hFF -> after transfer at pc 2, halted=1, instr_valid=0; branch to 16'h0010 -> fetch resumes at 16'h0010.
REQ-038 RESET_PC=16'hFFFF -> transfers at 16'hFFFF then 16'h0000.
REQ-039 reset_n pulsed low with FIFO full -> instr_valid=0 immediately, IDLE; with FETCH_CTRL_PERF_EN, perf_fetch_count=0.
